ultrasonic_trig_gen: RTL and testbench
======================================

# ultrasonic_trig_gen

Transmit-side controller for one ultrasonic ranging channel. It issues the periodic trigger pulse to the sensor and supervises the returning echo line. It reports completion, missing-echo and over-range events. It sits alongside the echo-width counter of the same channel, which measures the pulse width, and paces that counter's measurements so that the obstacle-avoidance logic gets one fresh sample per period.

## Interface
Parameters:
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 us at 50 MHz); legal range 1..1023.
- RISE_TIMEOUT, 1_500_000: maximum cycles from trigger fall to echo rise.
- FALL_TIMEOUT, 1_200_000: maximum echo high time in cycles, about 4 m range.
- PERIOD_CYCLES, 3_000_000: trigger-rise to trigger-rise spacing (60 ms).
- Constraint: PERIOD_CYCLES ≥ TRIG_CYCLES + RISE_TIMEOUT + FALL_TIMEOUT + 4.
- Constraint: every count must fit in 22 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; while high, measurement cycles repeat.
- echo  in  1  sensor echo line (asynchronous to clk).
- trig  out  1  registered trigger to sensor.
- busy  out  1  high from trigger start until the cycle ends, that is, until HOLDOFF exits.
- done  out  1  one-cycle pulse on echo fall inside the window (valid echo).
- no_echo  out  1  one-cycle pulse on echo rise timeout.
- over_range  out  1  one-cycle pulse on echo fall timeout.

## Operation
- Reset (rst_n=0, asynchronous): state IDLE.
- All outputs reset to 0, and all counters reset to 0.
- Let echo_i be the internal echo: synchronized or raw, per Configuration.
- FSM states: IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF.
- IDLE: when enable=1, go to TRIG and clear the period counter.
- TRIG: trig=1. After exactly TRIG_CYCLES cycles, go to WAIT_RISE with trig=0 and the phase counter cleared.
- WAIT_RISE:
  - echo_i=1 → WAIT_FALL, phase counter cleared.
  - phase counter reaches RISE_TIMEOUT → pulse no_echo, go to HOLDOFF.
  - If both happen in the same cycle, the echo rise wins.
- WAIT_FALL:
  - echo_i=0 → pulse done, go to HOLDOFF.
  - phase counter reaches FALL_TIMEOUT → pulse over_range, go to HOLDOFF.
  - If both happen in the same cycle, done wins.
- HOLDOFF:
  - Wait until the period counter reaches PERIOD_CYCLES-1.
  - Then go to TRIG if enable=1, else go to IDLE.
  - echo activity here is ignored.
- The period counter is 22 bits. It counts every cycle from the first TRIG cycle and saturates at PERIOD_CYCLES-1; it never wraps.
- The phase counter is 22 bits, clears on every state entry, and saturates.
- enable=0 mid-cycle: the current cycle completes, including the full HOLDOFF, and the FSM then returns to IDLE. trig is never truncated.
- echo already high on entry to WAIT_RISE (stuck echo) → it counts as a rise immediately.
- Exactly one of done, no_echo or over_range pulses per trigger.
- Reset mid-operation: trig drops immediately (asynchronously), and no status pulse is emitted.

## Timing
- Latency from enable high in IDLE to trig high: 1 cycle.
- trig high for exactly TRIG_CYCLES cycles.
- Trigger rise to next trigger rise: exactly PERIOD_CYCLES cycles while enable stays 1.
- echo_i to status output: 1 cycle, since outputs are registered.
- Each status pulse is exactly 1 cycle wide.
- busy rises together with trig and falls on the cycle the FSM leaves HOLDOFF for IDLE.
- With continuous enable, busy stays 1.

## Configuration
- Macro: ULTRASONIC_ECHO_SYNC_EN.
- Defined: echo passes a 2-flop synchronizer (both flops reset to 0) before the FSM. This adds 2 cycles of echo-to-status latency.
- Undefined: echo feeds the FSM directly, for use when echo is already synchronous (simulation or an external synchronizer).
- Trigger timing is identical in both builds.

## Test plan
Parameters for all scenarios: TRIG=4, RISE=8, FALL=20, PERIOD=50. The macro is undefined unless stated.
- Nominal:
  - Stimulus: enable=1; echo rises 3 cycles after trig falls and stays high 10 cycles.
  - Response: trig high 4 cycles; done pulses 1 cycle after echo falls; next trig rises 50 cycles after the first; no_echo and over_range stay 0.
- No echo:
  - Stimulus: echo held at 0.
  - Response: no_echo pulses once, 8 cycles after trig falls; the next trigger still follows at 50 cycles.
- Over-range:
  - Stimulus: echo rises and stays high.
  - Response: over_range pulses 20 cycles after the rise; no done pulse; echo is ignored in HOLDOFF.
- Enable drop:
  - Stimulus: enable falls during WAIT_FALL.
  - Response: done still pulses; busy falls 50 cycles after trig rise; no further trig.
- Async reset:
  - Stimulus: rst_n pulsed low mid-TRIG.
  - Response: trig=0 within the same cycle; all outputs 0; restart 1 cycle after enable is seen.
- Sync build:
  - Stimulus: repeat the nominal scenario with ULTRASONIC_ECHO_SYNC_EN defined.
  - Response: done appears 2 cycles later than in the nominal run.

Source files
------------

// File: rtl/ultrasonic_trig_gen.sv
// Trigger generator and echo supervisor for one ultrasonic ranging channel.
// Optional build macro ULTRASONIC_ECHO_SYNC_EN adds a 2-flop synchronizer on echo.
module ultrasonic_trig_gen #(
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned RISE_TIMEOUT  = 1_500_000,
    parameter int unsigned FALL_TIMEOUT  = 1_200_000,
    parameter int unsigned PERIOD_CYCLES = 3_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic echo,
    output logic trig,
    output logic busy,
    output logic done,
    output logic no_echo,
    output logic over_range
);

    localparam int unsigned CW = 22;
    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [CW-1:0] COUNT_MAX   = '1;
    localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] RISE_LAST   = CW'(RISE_TIMEOUT - 1);
    localparam logic [CW-1:0] FALL_LAST   = CW'(FALL_TIMEOUT - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        WAIT_FALL,
        HOLDOFF
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] phase;
    logic [CW-1:0] phase_next;
    logic [CW-1:0] period;
    logic [CW-1:0] period_next;
    logic          done_next;
    logic          no_echo_next;
    logic          over_range_next;
    logic          echo_i;

`ifdef ULTRASONIC_ECHO_SYNC_EN
    logic [1:0] echo_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_sync <= 2'b00;
        end else begin
            echo_sync <= {echo_sync[0], echo};
        end
    end

    assign echo_i = echo_sync[1];
`else
    assign echo_i = echo;
`endif

    // Phase counts time within a state; period spans one full trigger-to-trigger cycle.
    always_comb begin
        state_next      = state;
        phase_next      = (phase == COUNT_MAX) ? phase : phase + ONE;
        period_next     = (period == PERIOD_LAST) ? period : period + ONE;
        done_next       = 1'b0;
        no_echo_next    = 1'b0;
        over_range_next = 1'b0;

        unique case (state)
            IDLE: begin
                phase_next  = '0;
                period_next = period;
                if (enable) begin
                    state_next  = TRIG;
                    period_next = '0;
                end
            end
            TRIG: begin
                if (phase == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    phase_next = '0;
                end
            end
            WAIT_RISE: begin
                if (echo_i) begin
                    state_next = WAIT_FALL;
                    phase_next = '0;
                end else if (phase == RISE_LAST) begin
                    state_next   = HOLDOFF;
                    phase_next   = '0;
                    no_echo_next = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!echo_i) begin
                    state_next = HOLDOFF;
                    phase_next = '0;
                    done_next  = 1'b1;
                end else if (phase == FALL_LAST) begin
                    state_next      = HOLDOFF;
                    phase_next      = '0;
                    over_range_next = 1'b1;
                end
            end
            HOLDOFF: begin
                if (period == PERIOD_LAST) begin
                    phase_next = '0;
                    if (enable) begin
                        state_next  = TRIG;
                        period_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so trig and busy rise on the entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            period     <= '0;
            trig       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            no_echo    <= 1'b0;
            over_range <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            period     <= period_next;
            trig       <= (state_next == TRIG);
            busy       <= (state_next != IDLE);
            done       <= done_next;
            no_echo    <= no_echo_next;
            over_range <= over_range_next;
        end
    end

endmodule

// File: tb/tb_ultrasonic_trig_gen.sv
// Randomized bench for ultrasonic_trig_gen: each trigger's echo window is evaluated
// from timing rules and compared cycle by cycle against the DUT outputs.
module tb_ultrasonic_trig_gen;

    localparam int TRIG   = 4;
    localparam int RISE   = 8;
    localparam int FALL   = 20;
    localparam int PERIOD = 50;
    localparam int N      = 400;
    localparam int SEGS   = 8;
    localparam int ES_LEN = N + 64;
`ifdef ULTRASONIC_ECHO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic echo = 1'b0;
    logic trig, busy, done, no_echo, over_range;

    int tests = 0;
    int failures = 0;
    int seg_id = 0;

    bit en_seq[N];
    bit echo_seq[N];
    bit es[ES_LEN];
    bit x_trig[N];
    bit x_busy[N];
    bit x_done[N];
    bit x_noecho[N];
    bit x_over[N];

    ultrasonic_trig_gen #(
        .TRIG_CYCLES(TRIG),
        .RISE_TIMEOUT(RISE),
        .FALL_TIMEOUT(FALL),
        .PERIOD_CYCLES(PERIOD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .echo(echo),
        .trig(trig),
        .busy(busy),
        .done(done),
        .no_echo(no_echo),
        .over_range(over_range)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected, input int cyc);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s seg %0d cycle %0d: observed %b expected %b", tag, seg_id, cyc, observed, expected);
        end
    endtask

    task automatic setEcho(input int start, input int len);
        for (int k = start; k < start + len; k++)
            if (k >= 0 && k < ES_LEN) es[k] = 1'b1;
    endtask

    // es[k] is the echo level the controller evaluates at clock edge k (after any synchronizer).
    task automatic buildSegment(input int mode);
        int  t, t0, w, rise, fall, kind, r, d;
        bit  lvl;
        for (int n = 0; n < N; n++) begin
            en_seq[n] = 1'b0; x_trig[n] = 1'b0; x_busy[n] = 1'b0;
            x_done[n] = 1'b0; x_noecho[n] = 1'b0; x_over[n] = 1'b0;
        end
        for (int k = 0; k < ES_LEN; k++) es[k] = 1'b0;
        lvl = 1'b1;
        for (int n = 0; n < N; n++) begin
            if (mode != 0 && $urandom_range(0, 39) == 0) lvl = !lvl;
            en_seq[n] = lvl;
        end
        t = 1;
        while (t < N) begin
            if (en_seq[t-1]) begin
                t0 = t;
                w  = t0 + TRIG;
                kind = $urandom_range(0, 4);
                r = $urandom_range(1, RISE);
                d = $urandom_range(1, FALL);
                case (kind)
                    0: setEcho(w + r, d);
                    1: ;
                    2: setEcho(w + r, FALL + $urandom_range(1, 6));
                    3: setEcho(t0 + 1, TRIG + d);
                    default: setEcho(w + RISE, d);
                endcase
                if ($urandom_range(0, 1) == 1) setEcho(t0 + 40, $urandom_range(1, 8));
                for (int k = t0; k < t0 + TRIG && k < N; k++) x_trig[k] = 1'b1;
                for (int k = t0; k < t0 + PERIOD && k < N; k++) x_busy[k] = 1'b1;
                rise = -1;
                for (int k = w + 1; k <= w + RISE; k++)
                    if (rise < 0 && es[k]) rise = k;
                if (rise < 0) begin
                    if (w + RISE < N) x_noecho[w + RISE] = 1'b1;
                end else begin
                    fall = -1;
                    for (int j = rise + 1; j <= rise + FALL; j++)
                        if (fall < 0 && !es[j]) fall = j;
                    if (fall >= 0) begin
                        if (fall < N) x_done[fall] = 1'b1;
                    end else if (rise + FALL < N) begin
                        x_over[rise + FALL] = 1'b1;
                    end
                end
                t = t0 + PERIOD;
            end else begin
                t++;
            end
        end
        for (int n = 0; n < N; n++) echo_seq[n] = es[n + 1 + LAT];
    endtask

    task automatic applyStimulus(input int mode);
        buildSegment(mode);
        rst_n = 1'b0; enable = 1'b0; echo = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < N; n++) begin
            if (n > 0) @(negedge clk);
            checkOutput("trig", trig, x_trig[n], n);
            checkOutput("busy", busy, x_busy[n], n);
            checkOutput("done", done, x_done[n], n);
            checkOutput("no_echo", no_echo, x_noecho[n], n);
            checkOutput("over_range", over_range, x_over[n], n);
            enable = en_seq[n];
            echo   = echo_seq[n];
        end
    endtask

    initial begin
        // Async reset in the middle of a trigger pulse, then restart.
        rst_n = 1'b0; enable = 1'b0; echo = 1'b0;
        @(negedge clk);
        checkOutput("reset_trig", trig, 1'b0, 0);
        checkOutput("reset_busy", busy, 1'b0, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        checkOutput("start_trig", trig, 1'b1, 1);
        @(negedge clk);
        checkOutput("mid_trig", trig, 1'b1, 2);
        checkOutput("mid_busy", busy, 1'b1, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_trig", trig, 1'b0, 2);
        checkOutput("async_busy", busy, 1'b0, 2);
        checkOutput("async_done", done, 1'b0, 2);
        checkOutput("async_no_echo", no_echo, 1'b0, 2);
        checkOutput("async_over_range", over_range, 1'b0, 2);
        @(negedge clk);
        checkOutput("held_trig", trig, 1'b0, 3);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_trig", trig, 1'b1, 4);
        checkOutput("restart_busy", busy, 1'b1, 4);

        for (int s = 0; s < SEGS; s++) begin
            seg_id = s + 1;
            applyStimulus((s == 0) ? 0 : 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
